// File: rtl/responder_round_ctrl.sv
// Round sequencer and contestant arbiter for the 4-key quiz responder:
// key conditioning, rotating-priority grant, answer countdown, scoring and false-start flags.
module responder_round_ctrl #(
    parameter int TICK_CYC     = 50000000,
    parameter int ANSWER_SEC   = 30,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int SCORE_MAX    = 9
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [3:0]  Key_In,
    input  logic        Judge_Ok,
    input  logic        Judge_Bad,
    input  logic        Score_Clr,
    output logic [2:0]  State_Out,
    output logic [1:0]  Winner,
    output logic        Winner_Valid,
    output logic [3:0]  Led_Out,
    output logic [3:0]  Foul,
    output logic [5:0]  Rest_Sec,
    output logic        Over,
    output logic        Buzz_Req,
    output logic [15:0] Score_Out
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        LOCKED  = 3'd2,
        TIMEOUT = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int TW = $clog2(TICK_CYC + 1);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [5:0] REST_INIT = 6'(ANSWER_SEC);
    localparam logic [3:0] SMAX      = 4'(SCORE_MAX);

    state_t state, state_next;

    logic [3:0]    key_s1, key_s2, key_db;
    logic [DW-1:0] db_cnt [4];
    logic          start_s1, start_s2, start_d;
    logic          ok_s1, ok_s2, ok_d;
    logic          bad_s1, bad_s2, bad_d;

    logic [1:0]    winner_q, ptr_q, grant_idx;
    logic          valid_q, buzz_q, any_elig;
    logic [3:0]    foul_q;
    logic [5:0]    rest_q;
    logic [TW-1:0] tick_q;
    logic [3:0]    score_q [4];

    logic [3:0] pressed, eligible;
    logic       start_rise, ok_edge, bad_edge, judge_one, tick_wrap;

    // Keys synchronize to the released level so reset never looks like a press.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            key_s1   <= 4'hF;
            key_s2   <= 4'hF;
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_d  <= 1'b0;
            ok_s1    <= 1'b0;
            ok_s2    <= 1'b0;
            ok_d     <= 1'b0;
            bad_s1   <= 1'b0;
            bad_s2   <= 1'b0;
            bad_d    <= 1'b0;
        end else begin
            key_s1   <= Key_In;
            key_s2   <= key_s1;
            start_s1 <= Start;
            start_s2 <= start_s1;
            start_d  <= start_s2;
            ok_s1    <= Judge_Ok;
            ok_s2    <= ok_s1;
            ok_d     <= ok_s2;
            bad_s1   <= Judge_Bad;
            bad_s2   <= bad_s1;
            bad_d    <= bad_s2;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            key_db <= 4'hF;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (key_s2[i] == key_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
                    key_db[i] <= key_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pressed    = ~key_db;
    assign eligible   = pressed & ~foul_q;
    assign start_rise = start_s2 & ~start_d;
    assign ok_edge    = ok_s2 & ~ok_d;
    assign bad_edge   = bad_s2 & ~bad_d;
    assign judge_one  = ok_edge ^ bad_edge;
    assign tick_wrap  = (tick_q == TW'(TICK_CYC - 1));

    // Rotating-priority scan starting at the pointer.
    always_comb begin
        logic [1:0] idx;
        idx       = '0;
        any_elig  = 1'b0;
        grant_idx = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!any_elig && eligible[idx]) begin
                any_elig  = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state != IDLE && !start_s2) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_rise) state_next = ARMED;
                ARMED:   if (any_elig) state_next = LOCKED;
                LOCKED: begin
                    if (judge_one)                           state_next = DONE;
                    else if (tick_wrap && rest_q == 6'd1)    state_next = TIMEOUT;
                end
                TIMEOUT: state_next = TIMEOUT;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // A judge edge coinciding with the last decrement still lets Rest_Sec reach 0.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            winner_q <= '0;
            valid_q  <= 1'b0;
            foul_q   <= '0;
            buzz_q   <= 1'b0;
            rest_q   <= REST_INIT;
            tick_q   <= '0;
            ptr_q    <= '0;
            for (int i = 0; i < 4; i++) score_q[i] <= '0;
        end else begin
            buzz_q <= 1'b0;
            if (state != IDLE && !start_s2) begin
                valid_q <= 1'b0;
                foul_q  <= '0;
                rest_q  <= REST_INIT;
                tick_q  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        foul_q <= foul_q | pressed;
                        if (start_rise) begin
                            rest_q <= REST_INIT;
                            tick_q <= '0;
                        end
                    end
                    ARMED: begin
                        if (any_elig) begin
                            winner_q <= grant_idx;
                            valid_q  <= 1'b1;
                            buzz_q   <= 1'b1;
                            ptr_q    <= grant_idx + 2'd1;
                        end
                    end
                    LOCKED: begin
                        if (tick_wrap) begin
                            tick_q <= '0;
                            if (rest_q != 6'd0) rest_q <= rest_q - 6'd1;
                            if (rest_q == 6'd1 && !judge_one) buzz_q <= 1'b1;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                        if (judge_one) begin
                            if (ok_edge) begin
                                if (score_q[winner_q] < SMAX)
                                    score_q[winner_q] <= score_q[winner_q] + 4'd1;
                            end else if (score_q[winner_q] != 4'd0) begin
                                score_q[winner_q] <= score_q[winner_q] - 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (Score_Clr) begin
                for (int i = 0; i < 4; i++) score_q[i] <= '0;
            end
        end
    end

    always_comb begin
        State_Out = state;
        Over      = (state == TIMEOUT);
        Led_Out   = valid_q ? (4'b0001 << winner_q) : 4'b0000;
    end

    assign Winner       = winner_q;
    assign Winner_Valid = valid_q;
    assign Foul         = foul_q;
    assign Rest_Sec     = rest_q;
    assign Buzz_Req     = buzz_q;
    assign Score_Out    = {score_q[3], score_q[2], score_q[1], score_q[0]};

endmodule

// File: tb/tb_responder_round_ctrl.sv
// Directed self-checking bench for responder_round_ctrl with short tick/debounce settings.
module tb_responder_round_ctrl;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [3:0]  Key_In;
    logic        Judge_Ok;
    logic        Judge_Bad;
    logic        Score_Clr;
    logic [2:0]  State_Out;
    logic [1:0]  Winner;
    logic        Winner_Valid;
    logic [3:0]  Led_Out;
    logic [3:0]  Foul;
    logic [5:0]  Rest_Sec;
    logic        Over;
    logic        Buzz_Req;
    logic [15:0] Score_Out;

    int total = 0;
    int bad   = 0;
    int buzz_cnt = 0;
    logic [1:0] win;

    responder_round_ctrl #(
        .TICK_CYC(10),
        .ANSWER_SEC(3),
        .DEBOUNCE_CYC(4),
        .SCORE_MAX(9)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .Key_In(Key_In),
        .Judge_Ok(Judge_Ok),
        .Judge_Bad(Judge_Bad),
        .Score_Clr(Score_Clr),
        .State_Out(State_Out),
        .Winner(Winner),
        .Winner_Valid(Winner_Valid),
        .Led_Out(Led_Out),
        .Foul(Foul),
        .Rest_Sec(Rest_Sec),
        .Over(Over),
        .Buzz_Req(Buzz_Req),
        .Score_Out(Score_Out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] keys, input logic start, input logic ok, input logic nok);
        Key_In    = keys;
        Start     = start;
        Judge_Ok  = ok;
        Judge_Bad = nok;
    endtask

    // Advance on falling edges so outputs are sampled mid-cycle; Buzz_Req pulses are tallied.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            if (Buzz_Req === 1'b1) buzz_cnt++;
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n = 0;
        while (State_Out !== st && n < budget) begin
            step(1);
            n++;
        end
        checkOutput(tag, 16'(State_Out), 16'(st));
    endtask

    task automatic wait_grant(input string tag, input int budget);
        int n = 0;
        while (Winner_Valid !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        checkOutput(tag, 16'(Winner_Valid), 16'd1);
    endtask

    // Full round: back to IDLE, arm, press keys, release, then optional judgement.
    task automatic run_round(input string tag, input logic [3:0] keys, input logic ok, input logic nok,
                             output logic [1:0] w);
        applyStimulus(4'hF, 1'b0, 1'b0, 1'b0);
        step(4);
        wait_state({tag, "_idle"}, 3'd0, 10);
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
        wait_state({tag, "_armed"}, 3'd1, 10);
        buzz_cnt = 0;
        applyStimulus(keys, 1'b1, 1'b0, 1'b0);
        wait_grant({tag, "_grant"}, 20);
        w = Winner;
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
        step(8);
        if (ok || nok) begin
            applyStimulus(4'hF, 1'b1, ok, nok);
            step(3);
            applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
            step(2);
        end
    endtask

    initial begin
        Reset = 1'b0;
        Score_Clr = 1'b0;
        applyStimulus(4'hF, 1'b0, 1'b0, 1'b0);
        step(3);
        checkOutput("rst_state", 16'(State_Out), 16'd0);
        checkOutput("rst_valid", 16'(Winner_Valid), 16'd0);
        checkOutput("rst_led", 16'(Led_Out), 16'd0);
        checkOutput("rst_rest", 16'(Rest_Sec), 16'd3);
        checkOutput("rst_score", Score_Out, 16'h0000);
        Reset = 1'b1;
        step(2);

        // Single press of key 1
        run_round("r1", 4'b1101, 1'b1, 1'b0, win);
        checkOutput("r1_winner", 16'(win), 16'd1);
        checkOutput("r1_led", 16'(Led_Out), 16'h0002);
        checkOutput("r1_buzz", 16'(buzz_cnt), 16'd1);
        checkOutput("r1_state", 16'(State_Out), 16'd4);
        checkOutput("r1_score", Score_Out, 16'h0010);

        // Tie of keys 0 and 3: pointer 2 picks 3, then pointer 0 picks 0
        run_round("r2", 4'b0110, 1'b0, 1'b1, win);
        checkOutput("r2_winner", 16'(win), 16'd3);
        checkOutput("r2_score_floor", Score_Out, 16'h0010);
        run_round("r3", 4'b0110, 1'b1, 1'b0, win);
        checkOutput("r3_winner", 16'(win), 16'd0);
        checkOutput("r3_score", Score_Out, 16'h0011);

        // False start on key 2
        applyStimulus(4'hF, 1'b0, 1'b0, 1'b0);
        step(4);
        applyStimulus(4'b1011, 1'b0, 1'b0, 1'b0);
        step(10);
        checkOutput("foul_set", 16'(Foul), 16'h0004);
        applyStimulus(4'b1011, 1'b1, 1'b0, 1'b0);
        wait_state("foul_armed", 3'd1, 10);
        step(10);
        checkOutput("foul_no_grant", 16'(Winner_Valid), 16'd0);
        applyStimulus(4'b1010, 1'b1, 1'b0, 1'b0);
        wait_grant("foul_grant", 20);
        checkOutput("foul_winner", 16'(Winner), 16'd0);
        checkOutput("foul_sticky", 16'(Foul), 16'h0004);
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
        step(8);
        applyStimulus(4'hF, 1'b1, 1'b1, 1'b0);
        step(3);
        applyStimulus(4'hF, 1'b0, 1'b0, 1'b0);
        step(4);
        checkOutput("foul_cleared", 16'(Foul), 16'h0000);
        checkOutput("foul_score", Score_Out, 16'h0012);

        // Countdown to timeout
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
        wait_state("to_armed", 3'd1, 10);
        buzz_cnt = 0;
        applyStimulus(4'b1101, 1'b1, 1'b0, 1'b0);
        wait_grant("to_grant", 20);
        checkOutput("to_rest3", 16'(Rest_Sec), 16'd3);
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
        step(9);
        checkOutput("to_rest3_late", 16'(Rest_Sec), 16'd3);
        step(1);
        checkOutput("to_rest2", 16'(Rest_Sec), 16'd2);
        step(19);
        checkOutput("to_rest1", 16'(Rest_Sec), 16'd1);
        checkOutput("to_still_locked", 16'(State_Out), 16'd2);
        step(1);
        checkOutput("to_rest0", 16'(Rest_Sec), 16'd0);
        checkOutput("to_state", 16'(State_Out), 16'd3);
        checkOutput("to_over", 16'(Over), 16'd1);
        checkOutput("to_buzz", 16'(buzz_cnt), 16'd2);
        applyStimulus(4'hF, 1'b1, 1'b1, 1'b0);
        step(3);
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
        step(3);
        checkOutput("to_judge_ignored", Score_Out, 16'h0012);
        checkOutput("to_led_held", 16'(Led_Out), 16'h0002);
        checkOutput("to_rest_floor", 16'(Rest_Sec), 16'd0);

        // Score clear, then saturation at 9
        Score_Clr = 1'b1;
        step(1);
        Score_Clr = 1'b0;
        checkOutput("score_clr", Score_Out, 16'h0000);
        for (int r = 0; r < 10; r++) begin
            run_round("sat", 4'b1110, 1'b1, 1'b0, win);
            checkOutput("sat_winner", 16'(win), 16'd0);
            if (r == 8) checkOutput("sat_nine", Score_Out, 16'h0009);
        end
        checkOutput("sat_hold", Score_Out, 16'h0009);
        run_round("floor", 4'b1101, 1'b0, 1'b1, win);
        checkOutput("floor_score", Score_Out, 16'h0009);

        // Bouncing key never debounces
        applyStimulus(4'hF, 1'b0, 1'b0, 1'b0);
        step(4);
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
        wait_state("bnc_armed", 3'd1, 10);
        for (int b = 0; b < 5; b++) begin
            applyStimulus(4'b1110, 1'b1, 1'b0, 1'b0);
            step(2);
            applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
            step(2);
        end
        step(6);
        checkOutput("bnc_no_grant", 16'(Winner_Valid), 16'd0);
        checkOutput("bnc_state", 16'(State_Out), 16'd1);

        // Start dropped while LOCKED
        applyStimulus(4'b1101, 1'b1, 1'b0, 1'b0);
        wait_grant("drop_grant", 20);
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
        step(8);
        checkOutput("drop_locked", 16'(State_Out), 16'd2);
        applyStimulus(4'hF, 1'b0, 1'b0, 1'b0);
        step(4);
        checkOutput("drop_state", 16'(State_Out), 16'd0);
        checkOutput("drop_led", 16'(Led_Out), 16'h0000);
        checkOutput("drop_valid", 16'(Winner_Valid), 16'd0);
        checkOutput("drop_rest", 16'(Rest_Sec), 16'd3);
        checkOutput("drop_score", Score_Out, 16'h0009);

        // Reset in the middle of LOCKED
        applyStimulus(4'hF, 1'b1, 1'b0, 1'b0);
        wait_state("mid_armed", 3'd1, 10);
        applyStimulus(4'b1011, 1'b1, 1'b0, 1'b0);
        wait_grant("mid_grant", 20);
        checkOutput("mid_winner", 16'(Winner), 16'd2);
        Reset = 1'b0;
        step(2);
        checkOutput("mid_rst_state", 16'(State_Out), 16'd0);
        checkOutput("mid_rst_winner", 16'(Winner), 16'd0);
        checkOutput("mid_rst_valid", 16'(Winner_Valid), 16'd0);
        checkOutput("mid_rst_led", 16'(Led_Out), 16'h0000);
        checkOutput("mid_rst_foul", 16'(Foul), 16'h0000);
        checkOutput("mid_rst_over", 16'(Over), 16'd0);
        checkOutput("mid_rst_buzz", 16'(Buzz_Req), 16'd0);
        checkOutput("mid_rst_rest", 16'(Rest_Sec), 16'd3);
        checkOutput("mid_rst_score", Score_Out, 16'h0000);
        applyStimulus(4'hF, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
